// File: rtl/frv_wb_arb_if.sv
// Bus bundle for the frv_wb_arb 2:1 Wishbone classic arbiter: imem and dmem
// request ports plus the shared memory bus, viewed from either side.
interface frv_wb_arb_if;
    logic        wb_imem_cyc_i;
    logic        wb_imem_stb_i;
    logic [31:0] wb_imem_adr_i;
    logic [31:0] wb_imem_dat_o;
    logic        wb_imem_ack_o;

    logic        wb_dmem_cyc_i;
    logic        wb_dmem_stb_i;
    logic        wb_dmem_we_i;
    logic [3:0]  wb_dmem_be_i;
    logic [31:0] wb_dmem_adr_i;
    logic [31:0] wb_dmem_dat_i;
    logic [31:0] wb_dmem_dat_o;
    logic        wb_dmem_ack_o;

    logic        wb_mem_cyc_o;
    logic        wb_mem_stb_o;
    logic        wb_mem_we_o;
    logic [3:0]  wb_mem_be_o;
    logic [31:0] wb_mem_adr_o;
    logic [31:0] wb_mem_dat_o;
    logic [31:0] wb_mem_dat_i;
    logic        wb_mem_ack_i;

    // Arbiter side.
    modport slave (
        input  wb_imem_cyc_i, wb_imem_stb_i, wb_imem_adr_i,
        output wb_imem_dat_o, wb_imem_ack_o,
        input  wb_dmem_cyc_i, wb_dmem_stb_i, wb_dmem_we_i, wb_dmem_be_i,
        input  wb_dmem_adr_i, wb_dmem_dat_i,
        output wb_dmem_dat_o, wb_dmem_ack_o,
        output wb_mem_cyc_o, wb_mem_stb_o, wb_mem_we_o, wb_mem_be_o,
        output wb_mem_adr_o, wb_mem_dat_o,
        input  wb_mem_dat_i, wb_mem_ack_i
    );

    // Core / memory side.
    modport master (
        output wb_imem_cyc_i, wb_imem_stb_i, wb_imem_adr_i,
        input  wb_imem_dat_o, wb_imem_ack_o,
        output wb_dmem_cyc_i, wb_dmem_stb_i, wb_dmem_we_i, wb_dmem_be_i,
        output wb_dmem_adr_i, wb_dmem_dat_i,
        input  wb_dmem_dat_o, wb_dmem_ack_o,
        input  wb_mem_cyc_o, wb_mem_stb_o, wb_mem_we_o, wb_mem_be_o,
        input  wb_mem_adr_o, wb_mem_dat_o,
        output wb_mem_dat_i, wb_mem_ack_i
    );
endinterface

// File: rtl/frv_wb_arb.sv
// 2:1 Wishbone classic arbiter merging frv_1 imem/dmem onto one memory bus.
// Define FRV_ARB_RR_EN for round-robin ties; otherwise dmem wins ties.
module frv_wb_arb #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_in,
    frv_wb_arb_if.slave  bus,
    output logic [1:0]   gnt_o,
    output logic         timeout_o
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic req_i, req_d, pick_d;
    logic active, wd_exp, done;

    assign req_i = bus.wb_imem_cyc_i & bus.wb_imem_stb_i;
    assign req_d = bus.wb_dmem_cyc_i & bus.wb_dmem_stb_i;

`ifdef FRV_ARB_RR_EN
    // Set when dmem was the last port served; a tie goes to the other one.
    logic last_d_q, last_d_d;
    assign pick_d = req_d & (~req_i | ~last_d_q);
`else
    assign pick_d = req_d;
`endif

    // Granted port still holds cyc; dropping it aborts the transfer.
    assign active = ((state_q == GNT_I) & bus.wb_imem_cyc_i)
                  | ((state_q == GNT_D) & bus.wb_dmem_cyc_i);
    assign wd_exp = (TIMEOUT != 0) && active && !bus.wb_mem_ack_i
                    && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign done   = active & (bus.wb_mem_ack_i | wd_exp);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
`ifdef FRV_ARB_RR_EN
        last_d_d = last_d_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_d)     state_d = GNT_D;
                else if (req_i) state_d = GNT_I;
            end
            GNT_I, GNT_D: begin
                if (!active || done) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
`ifdef FRV_ARB_RR_EN
                    last_d_d = (state_q == GNT_D);
`endif
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
`ifdef FRV_ARB_RR_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`ifdef FRV_ARB_RR_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    always_comb begin
        bus.wb_mem_cyc_o  = 1'b0;
        bus.wb_mem_stb_o  = 1'b0;
        bus.wb_mem_we_o   = 1'b0;
        bus.wb_mem_be_o   = 4'h0;
        bus.wb_mem_adr_o  = 32'h0;
        bus.wb_mem_dat_o  = 32'h0;
        bus.wb_imem_ack_o = 1'b0;
        bus.wb_dmem_ack_o = 1'b0;
        unique case (state_q)
            GNT_I: begin
                bus.wb_mem_cyc_o  = bus.wb_imem_cyc_i;
                bus.wb_mem_stb_o  = req_i;
                bus.wb_mem_be_o   = 4'hF;
                bus.wb_mem_adr_o  = bus.wb_imem_adr_i;
                bus.wb_imem_ack_o = done;
            end
            GNT_D: begin
                bus.wb_mem_cyc_o  = bus.wb_dmem_cyc_i;
                bus.wb_mem_stb_o  = req_d;
                bus.wb_mem_we_o   = bus.wb_dmem_we_i;
                bus.wb_mem_be_o   = bus.wb_dmem_be_i;
                bus.wb_mem_adr_o  = bus.wb_dmem_adr_i;
                bus.wb_mem_dat_o  = bus.wb_dmem_dat_i;
                bus.wb_dmem_ack_o = done;
            end
            default: ;
        endcase
    end

    // A watchdog-fabricated ack returns zero data.
    assign bus.wb_imem_dat_o = wd_exp ? 32'h0 : bus.wb_mem_dat_i;
    assign bus.wb_dmem_dat_o = wd_exp ? 32'h0 : bus.wb_mem_dat_i;

    assign gnt_o     = {state_q == GNT_D, state_q == GNT_I};
    assign timeout_o = wd_exp;
endmodule

// File: tb/tb_frv_wb_arb.sv
// Directed self-checking bench for frv_wb_arb (TIMEOUT=8); expectations
// follow FRV_ARB_RR_EN when that macro is defined for the build.
module tb_frv_wb_arb;
    logic       clk;
    logic       rst_n;
    logic [1:0] gnt;
    logic       tmo;
    int         n_checks = 0;
    int         n_errors = 0;

`ifdef FRV_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    frv_wb_arb_if bus ();

    frv_wb_arb #(.TIMEOUT(8)) dut (
        .clk_i     (clk),
        .rst_in    (rst_n),
        .bus       (bus),
        .gnt_o     (gnt),
        .timeout_o (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.wb_imem_cyc_i = 1'b0; bus.wb_imem_stb_i = 1'b0; bus.wb_imem_adr_i = 32'h0;
        bus.wb_dmem_cyc_i = 1'b0; bus.wb_dmem_stb_i = 1'b0; bus.wb_dmem_we_i  = 1'b0;
        bus.wb_dmem_be_i  = 4'h0; bus.wb_dmem_adr_i = 32'h0; bus.wb_dmem_dat_i = 32'h0;
        bus.wb_mem_ack_i  = 1'b0; bus.wb_mem_dat_i  = 32'h0;
    endtask

    task automatic dmem_req(input logic we, input logic [3:0] be,
                            input logic [31:0] adr, input logic [31:0] dat);
        bus.wb_dmem_cyc_i = 1'b1; bus.wb_dmem_stb_i = 1'b1; bus.wb_dmem_we_i = we;
        bus.wb_dmem_be_i  = be;   bus.wb_dmem_adr_i = adr;  bus.wb_dmem_dat_i = dat;
    endtask

    initial begin
        logic [1:0] exp_gnt;
        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk("reset_gnt", gnt, 2'b00);
        chk("reset_mem_cyc", bus.wb_mem_cyc_o, 1'b0);
        chk("reset_mem_adr", bus.wb_mem_adr_o, 32'h0);
        chk("reset_acks", {bus.wb_imem_ack_o, bus.wb_dmem_ack_o}, 2'b00);
        chk("reset_timeout", tmo, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // imem fetch: one cycle of arbitration latency, then ack with 0x13.
        step();
        bus.wb_imem_cyc_i = 1'b1; bus.wb_imem_stb_i = 1'b1; bus.wb_imem_adr_i = 32'h10;
        #1;
        chk("imem_latency_gnt", gnt, 2'b00);
        chk("imem_latency_cyc", bus.wb_mem_cyc_o, 1'b0);
        step();
        chk("imem_gnt", gnt, 2'b01);
        chk("imem_mem_cyc_stb", {bus.wb_mem_cyc_o, bus.wb_mem_stb_o}, 2'b11);
        chk("imem_mem_adr", bus.wb_mem_adr_o, 32'h10);
        chk("imem_mem_we", bus.wb_mem_we_o, 1'b0);
        chk("imem_mem_be", bus.wb_mem_be_o, 4'hF);
        chk("imem_no_ack_yet", bus.wb_imem_ack_o, 1'b0);
        bus.wb_mem_ack_i = 1'b1; bus.wb_mem_dat_i = 32'h0000_0013;
        #1;
        chk("imem_ack", bus.wb_imem_ack_o, 1'b1);
        chk("imem_dat", bus.wb_imem_dat_o, 32'h0000_0013);
        chk("imem_dmem_ack_off", bus.wb_dmem_ack_o, 1'b0);
        step();
        idle_inputs();
        #1;
        chk("imem_back_idle", gnt, 2'b00);

        // dmem write passes straight through.
        dmem_req(1'b1, 4'h3, 32'h2000, 32'hCAFE_F00D);
        step();
        chk("dw_gnt", gnt, 2'b10);
        chk("dw_mem_we", bus.wb_mem_we_o, 1'b1);
        chk("dw_mem_be", bus.wb_mem_be_o, 4'h3);
        chk("dw_mem_adr", bus.wb_mem_adr_o, 32'h2000);
        chk("dw_mem_dat", bus.wb_mem_dat_o, 32'hCAFE_F00D);
        chk("dw_ack_wait", bus.wb_dmem_ack_o, 1'b0);
        bus.wb_mem_ack_i = 1'b1;
        #1;
        chk("dw_ack", bus.wb_dmem_ack_o, 1'b1);
        chk("dw_imem_ack_off", bus.wb_imem_ack_o, 1'b0);
        step();
        idle_inputs();
        #1;
        chk("dw_back_idle", gnt, 2'b00);

        // Fresh reset so the round-robin flag starts at "imem served last".
        rst_n = 1'b0;
        #1;
        chk("rr_reset_gnt", gnt, 2'b00);
        @(negedge clk) rst_n = 1'b1;

        // Four simultaneous requests: fixed -> D,D,D,D; round-robin -> D,I,D,I.
        bus.wb_imem_cyc_i = 1'b1; bus.wb_imem_stb_i = 1'b1; bus.wb_imem_adr_i = 32'h40;
        dmem_req(1'b0, 4'hF, 32'h3000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_gnt = (RR && (i % 2 == 1)) ? 2'b01 : 2'b10;
            chk($sformatf("tie%0d_gnt", i), gnt, exp_gnt);
            bus.wb_mem_ack_i = 1'b1;
            #1;
            chk($sformatf("tie%0d_acks", i), {bus.wb_dmem_ack_o, bus.wb_imem_ack_o}, exp_gnt);
            step();
            bus.wb_mem_ack_i = 1'b0;
            #1;
            chk($sformatf("tie%0d_idle", i), gnt, 2'b00);
        end
        idle_inputs();
        step();

        // Watchdog expiry: never acked, fabricated ack on the 8th granted cycle.
        dmem_req(1'b0, 4'hF, 32'h4000, 32'h0);
        bus.wb_mem_dat_i = 32'hDEAD_BEEF;
        step();
        chk("wd_gnt", gnt, 2'b10);
        for (int k = 1; k <= 8; k++) begin
            if (k < 8) begin
                chk($sformatf("wd_wait%0d_tmo", k), tmo, 1'b0);
                chk($sformatf("wd_wait%0d_ack", k), bus.wb_dmem_ack_o, 1'b0);
                step();
            end else begin
                chk("wd_expire_tmo", tmo, 1'b1);
                chk("wd_expire_ack", bus.wb_dmem_ack_o, 1'b1);
                chk("wd_expire_dat", bus.wb_dmem_dat_o, 32'h0);
                chk("wd_expire_imem_ack", bus.wb_imem_ack_o, 1'b0);
            end
        end
        step();
        chk("wd_idle_gnt", gnt, 2'b00);
        chk("wd_idle_tmo", tmo, 1'b0);
        idle_inputs();
        step();

        // Real ack on the expiry cycle wins over the watchdog.
        dmem_req(1'b0, 4'hF, 32'h4004, 32'h0);
        bus.wb_mem_dat_i = 32'h1234_5678;
        step();
        for (int k = 1; k < 8; k++) step();
        bus.wb_mem_ack_i = 1'b1;
        #1;
        chk("wd_race_gnt", gnt, 2'b10);
        chk("wd_race_tmo", tmo, 1'b0);
        chk("wd_race_ack", bus.wb_dmem_ack_o, 1'b1);
        chk("wd_race_dat", bus.wb_dmem_dat_o, 32'h1234_5678);
        step();
        idle_inputs();
        step();

        // imem abort after 2 granted cycles; later acks are ignored.
        bus.wb_imem_cyc_i = 1'b1; bus.wb_imem_stb_i = 1'b1; bus.wb_imem_adr_i = 32'h80;
        step();
        chk("ab_gnt", gnt, 2'b01);
        step();
        chk("ab_cyc_held", bus.wb_mem_cyc_o, 1'b1);
        bus.wb_imem_cyc_i = 1'b0; bus.wb_imem_stb_i = 1'b0;
        #1;
        chk("ab_mem_cyc_stb", {bus.wb_mem_cyc_o, bus.wb_mem_stb_o}, 2'b00);
        bus.wb_mem_ack_i = 1'b1;
        #1;
        chk("ab_no_ack", {bus.wb_imem_ack_o, bus.wb_dmem_ack_o}, 2'b00);
        step();
        chk("ab_idle_gnt", gnt, 2'b00);
        chk("ab_late_ack_ignored", {bus.wb_imem_ack_o, bus.wb_dmem_ack_o}, 2'b00);
        idle_inputs();
        step();

        // Reset mid-transfer forces outputs low at once; re-grant right after.
        dmem_req(1'b1, 4'hF, 32'h5000, 32'h5555_AAAA);
        step();
        chk("rst_pre_gnt", gnt, 2'b10);
        bus.wb_mem_ack_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_gnt", gnt, 2'b00);
        chk("rst_async_cyc", bus.wb_mem_cyc_o, 1'b0);
        chk("rst_async_we", bus.wb_mem_we_o, 1'b0);
        chk("rst_async_dat", bus.wb_mem_dat_o, 32'h0);
        chk("rst_async_ack", bus.wb_dmem_ack_o, 1'b0);
        bus.wb_mem_ack_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("rst_regrant_gnt", gnt, 2'b10);
        chk("rst_regrant_adr", bus.wb_mem_adr_o, 32'h5000);
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
